// File: rtl/echo_arb_pkg.sv
// Shared types and the round-robin pick helper for the echo arbiter.
// Tags are sized for the largest supported requester count so that every file shares one tag type.
package echo_arb_pkg;

    localparam int NUM_REQ_MAX = 8;
    localparam int TAG_W       = $clog2(NUM_REQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t idx;
    } pick_t;

    // Walks the requesters starting at ptr and wraps at num, so the first active index wins.
    function automatic pick_t rr_pick(input logic [NUM_REQ_MAX-1:0] req,
                                      input tag_t ptr,
                                      input int unsigned num);
        pick_t p;
        tag_t  cand;
        p    = '0;
        cand = ptr;
        for (int unsigned k = 0; k < NUM_REQ_MAX; k++) begin
            if (k < num) begin
                if (!p.valid && req[cand]) begin
                    p.valid = 1'b1;
                    p.idx   = cand;
                end
                cand = (cand == tag_t'(num - 1)) ? '0 : cand + 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/echo_tag_fifo.sv
// Circular buffer of requester tags using the enq/first/deq method convention.
// DEPTH is a power of two, at least 2.
module echo_tag_fifo
    import echo_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enq__ENA,
    input  logic [TAG_W-1:0]         enq_v,
    output logic                     enq__RDY,
    input  logic                     deq__ENA,
    output logic                     deq__RDY,
    output logic [TAG_W-1:0]         first,
    output logic                     first__RDY,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    tag_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doEnq, doDeq;

    assign enq__RDY   = (count_q < CNT_W'(DEPTH));
    assign deq__RDY   = (count_q != '0);
    assign first__RDY = deq__RDY;
    assign first      = mem_q[rd_q];
    assign count      = count_q;

    assign doEnq = enq__ENA & enq__RDY;
    assign doDeq = deq__ENA & deq__RDY;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (doEnq) begin
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (doDeq) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({doEnq, doDeq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (doEnq) begin
            mem_q[wr_q] <= enq_v;
        end
    end

endmodule

// File: rtl/echo_rr_arbiter.sv
// Round-robin arbiter sharing one in-order echo datapath among NUM_REQ requesters;
// a tag FIFO remembers who issued each request so responses route back to the issuer.
module echo_rr_arbiter
    import echo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req__ENA,
    input  logic [NUM_REQ*DATA_W-1:0]   req_v,
    output logic [NUM_REQ-1:0]          req__RDY,
    output logic                        echoReq__ENA,
    output logic [DATA_W-1:0]           echoReq_v,
    input  logic                        echoReq__RDY,
    input  logic                        resp__ENA,
    input  logic [DATA_W-1:0]           resp_v,
    output logic                        resp__RDY,
    output logic [NUM_REQ-1:0]          ind__ENA,
    output logic [DATA_W-1:0]           ind_v,
    input  logic [NUM_REQ-1:0]          ind__RDY,
    output logic [$clog2(TAG_DEPTH):0]  outstanding,
    output logic                        err
);

    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    tag_t                   rr_q, rr_d;
    logic                   err_q, err_d;
    logic [NUM_REQ_MAX-1:0] reqPad;
    logic [NUM_REQ_MAX-1:0] indRdyPad;
    pick_t                  pick;
    logic                   canIssue;
    logic                   grantValid;
    logic                   tagEnqRdy;
    logic                   tagDeqRdy;
    logic                   tagFirstRdy;
    logic                   tagDeq;
    tag_t                   tagHead;
    logic [CNT_W-1:0]       tagCount;

    // Full check looks only at the current count, so a response never feeds the grant path.
    always_comb begin
        reqPad                = '0;
        reqPad[NUM_REQ-1:0]   = req__ENA;
        canIssue              = echoReq__RDY & tagEnqRdy & ~RST;
        pick                  = rr_pick(reqPad, rr_q, NUM_REQ);
        grantValid            = canIssue & pick.valid;
        req__RDY              = '0;
        echoReq_v             = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantValid && (pick.idx == TAG_W'(i))) begin
                req__RDY[i] = 1'b1;
                echoReq_v   = req_v[i*DATA_W +: DATA_W];
            end
        end
        echoReq__ENA = |(req__ENA & req__RDY);
    end

    always_comb begin
        indRdyPad              = '0;
        indRdyPad[NUM_REQ-1:0] = ind__RDY;
        resp__RDY              = tagFirstRdy & indRdyPad[tagHead] & ~RST;
        tagDeq                 = resp__ENA & resp__RDY;
        ind__ENA               = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tagDeq && (tagHead == TAG_W'(i))) begin
                ind__ENA[i] = 1'b1;
            end
        end
        ind_v = resp_v;
    end

    // A response with nothing outstanding can only be a protocol violation; remember it.
    always_comb begin
        rr_d  = rr_q;
        err_d = err_q | (resp__ENA & ~tagDeqRdy);
        if (grantValid) begin
            rr_d = (pick.idx == TAG_W'(NUM_REQ - 1)) ? '0 : pick.idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    echo_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tagFifo (
        .CLK        (CLK),
        .RST        (RST),
        .enq__ENA   (grantValid),
        .enq_v      (pick.idx),
        .enq__RDY   (tagEnqRdy),
        .deq__ENA   (tagDeq),
        .deq__RDY   (tagDeqRdy),
        .first      (tagHead),
        .first__RDY (tagFirstRdy),
        .count      (tagCount)
    );

    assign outstanding = tagCount;
    assign err         = err_q;

endmodule

// File: tb/tb_echo_rr_arbiter.sv
// Self-checking bench for echo_rr_arbiter: the bench plays the in-order echo block and keeps
// a queue-based reference of outstanding issuers, the rotating priority and the error flag.
module tb_echo_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TD = 4;

   logic              CLK = 1'b0;
   logic              RST;
   logic [N-1:0]      req__ENA;
   logic [N*DW-1:0]   req_v;
   logic [N-1:0]      req__RDY;
   logic              echoReq__ENA;
   logic [DW-1:0]     echoReq_v;
   logic              echoReq__RDY;
   logic              resp__ENA;
   logic [DW-1:0]     resp_v;
   logic              resp__RDY;
   logic [N-1:0]      ind__ENA;
   logic [DW-1:0]     ind_v;
   logic [N-1:0]      ind__RDY;
   logic [2:0]        outstanding;
   logic              err;

   int                testsRun = 0;
   int                testsFailed = 0;

   // Reference state: next priority position, issuers awaiting responses, their payloads.
   int                rrModel;
   int                tagQ[$];
   logic [DW-1:0]     dataQ[$];
   bit                errModel;

   logic [N-1:0]      lastGrant;
   logic [N-1:0]      lastIndEna;
   logic [DW-1:0]     lastEchoV;
   logic [DW-1:0]     lastIndV;
   logic              lastRespRdy;

   always #5 CLK = ~CLK;

   echo_rr_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (DW),
      .TAG_DEPTH (TD)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .req__ENA     (req__ENA),
      .req_v        (req_v),
      .req__RDY     (req__RDY),
      .echoReq__ENA (echoReq__ENA),
      .echoReq_v    (echoReq_v),
      .echoReq__RDY (echoReq__RDY),
      .resp__ENA    (resp__ENA),
      .resp_v       (resp_v),
      .resp__RDY    (resp__RDY),
      .ind__ENA     (ind__ENA),
      .ind_v        (ind_v),
      .ind__RDY     (ind__RDY),
      .outstanding  (outstanding),
      .err          (err)
   );

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs at the falling edge, checks every output against the
   // reference just after, then advances the reference across the rising edge.
   task automatic applyStimulus(input logic [N-1:0] ena, input logic [N*DW-1:0] vals,
                                input logic eRdy, input logic rEna,
                                input logic [N-1:0] iRdy, input bit forceResp);
      int            g;
      int            head;
      logic [N-1:0]  expReqRdy;
      logic [N-1:0]  expIndEna;
      logic [DW-1:0] expEchoV;
      logic [DW-1:0] respVal;
      bit            expRespRdy;
      bit            pop;
      bit            respSent;

      respSent     = rEna && (forceResp || tagQ.size() > 0);
      respVal      = (dataQ.size() > 0) ? dataQ[0] : DW'($urandom);
      req__ENA     = ena;
      req_v        = vals;
      echoReq__RDY = eRdy;
      ind__RDY     = iRdy;
      resp__ENA    = respSent;
      resp_v       = respVal;
      #1;

      g = -1;
      if (eRdy && tagQ.size() < TD) begin
         for (int k = 0; k < N; k++) begin
            if (ena[(rrModel + k) % N]) begin
               g = (rrModel + k) % N;
               break;
            end
         end
      end
      expReqRdy  = (g >= 0) ? (N'(1) << g) : '0;
      expEchoV   = (g >= 0) ? vals[g*DW +: DW] : '0;
      head       = (tagQ.size() > 0) ? tagQ[0] : -1;
      expRespRdy = (head >= 0) && iRdy[head];
      pop        = respSent && expRespRdy;
      expIndEna  = pop ? (N'(1) << head) : '0;

      checkOutput("req_rdy",     req__RDY,     expReqRdy);
      checkOutput("echo_ena",    echoReq__ENA, g >= 0);
      checkOutput("echo_v",      echoReq_v,    expEchoV);
      checkOutput("resp_rdy",    resp__RDY,    expRespRdy);
      checkOutput("ind_ena",     ind__ENA,     expIndEna);
      checkOutput("ind_v",       ind_v,        respVal);
      checkOutput("outstanding", outstanding,  tagQ.size());
      checkOutput("err",         err,          errModel);

      lastGrant   = req__RDY;
      lastIndEna  = ind__ENA;
      lastEchoV   = echoReq_v;
      lastIndV    = ind_v;
      lastRespRdy = resp__RDY;

      @(posedge CLK);
      if (respSent && tagQ.size() == 0) errModel = 1'b1;
      if (pop) begin
         void'(tagQ.pop_front());
         void'(dataQ.pop_front());
      end
      if (g >= 0) begin
         tagQ.push_back(g);
         dataQ.push_back(expEchoV);
         rrModel = (g + 1) % N;
      end
      @(negedge CLK);
   endtask

   task automatic drainQueue();
      for (int k = 0; k < 2 * TD && tagQ.size() > 0; k++) begin
         applyStimulus('0, '0, 1'b1, 1'b1, '1, 1'b0);
      end
      checkOutput("drain_empty", tagQ.size(), 0);
   endtask

   task automatic resetModel();
      rrModel  = 0;
      tagQ.delete();
      dataQ.delete();
      errModel = 1'b0;
   endtask

   initial begin
      logic [N*DW-1:0] v;
      resetModel();
      RST          = 1'b1;
      req__ENA     = '1;
      req_v        = '0;
      echoReq__RDY = 1'b1;
      resp__ENA    = 1'b0;
      resp_v       = '0;
      ind__RDY     = '1;
      #3;
      checkOutput("rst_req_rdy",  req__RDY,     0);
      checkOutput("rst_echo_ena", echoReq__ENA, 0);
      checkOutput("rst_resp_rdy", resp__RDY,    0);
      checkOutput("rst_ind_ena",  ind__ENA,     0);
      checkOutput("rst_outst",    outstanding,  0);
      checkOutput("rst_err",      err,          0);
      @(negedge CLK);
      RST = 1'b0;

      // Single request and its loopback response.
      v = '0;
      v[0 +: DW] = 32'h1234_5678;
      applyStimulus(4'b0001, v, 1'b1, 1'b0, '1, 1'b0);
      checkOutput("single_grant", lastGrant, 4'b0001);
      checkOutput("single_echo",  lastEchoV, 32'h1234_5678);
      checkOutput("single_outst", outstanding, 1);
      applyStimulus('0, '0, 1'b1, 1'b1, '1, 1'b0);
      checkOutput("single_ind",   lastIndEna, 4'b0001);
      checkOutput("single_ind_v", lastIndV, 32'h1234_5678);
      checkOutput("single_empty", outstanding, 0);

      // All requesters held: priority rotates starting after requester 0.
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < N; k++) v[k*DW +: DW] = 32'hA000_0000 + 32'(i * 16 + k);
         applyStimulus(4'b1111, v, 1'b1, 1'b1, '1, 1'b0);
         checkOutput("fair_order", lastGrant, N'(1) << ((1 + i) % N));
         if (i > 0) checkOutput("fair_route", lastIndEna, N'(1) << (i % N));
      end
      drainQueue();

      // Tag FIFO full stall, then one release.
      for (int i = 0; i < 5; i++) begin
         v = '0;
         v[2*DW +: DW] = 32'hC0DE_0000 + 32'(i);
         applyStimulus(4'b0100, v, 1'b1, 1'b0, '1, 1'b0);
         checkOutput("stall_grant", lastGrant, (i < TD) ? 4'b0100 : 4'b0000);
      end
      checkOutput("stall_outst", outstanding, TD);
      applyStimulus(4'b0100, v, 1'b1, 1'b1, '1, 1'b0);
      checkOutput("stall_no_grant_on_pop", lastGrant, 4'b0000);
      applyStimulus(4'b0100, v, 1'b1, 1'b0, '1, 1'b0);
      checkOutput("stall_regrant", lastGrant, 4'b0100);
      drainQueue();

      // Indication backpressure from the head's issuer.
      v = '0;
      v[1*DW +: DW] = 32'hBEEF_0001;
      applyStimulus(4'b0010, v, 1'b1, 1'b0, '1, 1'b0);
      applyStimulus('0, '0, 1'b1, 1'b1, 4'b1101, 1'b0);
      checkOutput("bp_resp_rdy", lastRespRdy, 0);
      checkOutput("bp_no_ind",   lastIndEna, 0);
      checkOutput("bp_outst",    outstanding, 1);
      applyStimulus('0, '0, 1'b1, 1'b1, 4'b1111, 1'b0);
      checkOutput("bp_ind",      lastIndEna, 4'b0010);
      checkOutput("bp_ind_v",    lastIndV, 32'hBEEF_0001);

      // Push and pop together keep occupancy at two while pointers wrap.
      applyStimulus(4'b1111, {N{32'h5555_0000}}, 1'b1, 1'b0, '1, 1'b0);
      applyStimulus(4'b1111, {N{32'h5555_0001}}, 1'b1, 1'b0, '1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
         applyStimulus(N'($urandom) | 4'b0001, v, 1'b1, 1'b1, '1, 1'b0);
         checkOutput("simul_outst", outstanding, 2);
      end

      // Randomized traffic against the reference.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
         applyStimulus(N'($urandom), v, ($urandom_range(3, 0) != 0), 1'($urandom),
                       N'($urandom) | N'($urandom), 1'b0);
      end
      drainQueue();

      // Response with nothing outstanding sets a sticky error.
      applyStimulus('0, '0, 1'b1, 1'b1, '1, 1'b1);
      checkOutput("err_no_ind", lastIndEna, 0);
      applyStimulus('0, '0, 1'b1, 1'b0, '1, 1'b0);
      applyStimulus(4'b0001, '0, 1'b1, 1'b0, '1, 1'b0);
      checkOutput("err_sticky", err, 1);

      // Asynchronous reset in the middle of traffic.
      applyStimulus(4'b1010, '0, 1'b1, 1'b0, '1, 1'b0);
      #2;
      RST       = 1'b1;
      req__ENA  = 4'b1111;
      resp__ENA = 1'b1;
      #1;
      checkOutput("arst_outst",    outstanding,  0);
      checkOutput("arst_err",      err,          0);
      checkOutput("arst_req_rdy",  req__RDY,     0);
      checkOutput("arst_echo_ena", echoReq__ENA, 0);
      checkOutput("arst_resp_rdy", resp__RDY,    0);
      checkOutput("arst_ind_ena",  ind__ENA,     0);
      resp__ENA = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      resetModel();
      applyStimulus(4'b1111, '0, 1'b1, 1'b0, '1, 1'b0);
      checkOutput("arst_rr_zero", lastGrant, 4'b0001);
      drainQueue();
      applyStimulus('0, '0, 1'b1, 1'b1, '1, 1'b1);
      applyStimulus('0, '0, 1'b1, 1'b0, '1, 1'b0);
      checkOutput("post_rst_err", err, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
